// File: rtl/mem_map_pkg.sv
// Shared memory map, word constants and stage state encoding for the
// routing pipeline stages that share the 16-bit word memory.
package mem_map_pkg;

    localparam int WORD_WIDTH    = 16;
    localparam int ADDR_WIDTH    = 11;
    localparam int MAX_NEIGHBORS = 64;

    localparam logic [10:0] NCOUNT_ADDR     = 11'h68A;
    localparam logic [10:0] KSCOUNT_ADDR    = 11'h688;
    localparam logic [10:0] KNOWNSINKS_BASE = 11'h008;
    localparam logic [10:0] WORSTHOPS_BASE  = 11'h028;
    localparam logic [10:0] QVALUE_BASE     = 11'h1C8;
    localparam logic [10:0] SINKIDS_BASE    = 11'h248;
    localparam logic [10:0] SIDCOUNT_BASE   = 11'h68E;
    localparam logic [10:0] BEST_ADDR       = 11'h68C;
    localparam logic [10:0] MINQ_ADDR       = 11'h686;

    localparam logic [15:0] NONE_WORD = 16'hFFFF;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_READY       = 4'd1,
        ST_RD_NC       = 4'd2,
        ST_RD_Q        = 4'd3,
        ST_RD_SC       = 4'd4,
        ST_WR_BEST     = 4'd5,
        ST_WR_MINQ_GAP = 4'd6,
        ST_WR_MINQ     = 4'd7,
        ST_FIN         = 4'd8
    } stage_state_e;

    // Tables hold one 16-bit entry every second word; wraps modulo 2^11.
    function automatic logic [10:0] table_addr(input logic [10:0] base,
                                               input logic [6:0]  idx);
        return base + {3'b000, idx, 1'b0};
    endfunction

endpackage

// File: rtl/neighbor_compare.sv
// Combinational win decision: lower qValue wins, equal qValue falls back
// to the larger sinkIDCount; exact ties lose so the first index is kept.
module neighbor_compare
    import mem_map_pkg::*;
(
    input  logic [WORD_WIDTH-1:0] q,
    input  logic [WORD_WIDTH-1:0] sc,
    input  logic [WORD_WIDTH-1:0] best_q,
    input  logic [WORD_WIDTH-1:0] best_sc,
    output logic                  win
);

    // Unsigned 16-bit compare of the candidate against the running best
    always_comb begin
        win = 1'b0;
        if (q < best_q) begin
            win = 1'b1;
        end else if ((q == best_q) && (sc > best_sc)) begin
            win = 1'b1;
        end else begin
            win = 1'b0;
        end
    end

endmodule

// File: rtl/select_best_neighbor.sv
// Scans the neighbour qValue / sinkIDCount tables and writes back the index
// and qValue of the best neighbour for the forwarding stage.
module select_best_neighbor
    import mem_map_pkg::*;
(
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] data_in,
    output logic [10:0]           address,
    output logic                  wr_en,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  done
);

    stage_state_e          state_q, state_d;
    logic [6:0]            i_q, i_d;
    logic [6:0]            nc_q, nc_d;
    logic [WORD_WIDTH-1:0] q_q, q_d;
    logic [WORD_WIDTH-1:0] best_idx_q, best_idx_d;
    logic [WORD_WIDTH-1:0] best_q_q, best_q_d;
    logic [WORD_WIDTH-1:0] best_sc_q, best_sc_d;
    logic [10:0]           address_q, address_d;
    logic                  wr_en_q, wr_en_d;
    logic [WORD_WIDTH-1:0] data_out_q, data_out_d;
    logic                  done_q, done_d;

    logic [6:0] nc_clamped_s;
    logic [6:0] i_next_s;
    logic       win_s;

    // Candidate sinkIDCount comes straight off data_in in RD_SC
    neighbor_compare u_cmp (
        .q       (q_q),
        .sc      (data_in),
        .best_q  (best_q_q),
        .best_sc (best_sc_q),
        .win     (win_s)
    );

    // Neighbour count clamp and loop index increment
    always_comb begin
        nc_clamped_s = 7'd0;
        if (data_in > 16'd64) begin
            nc_clamped_s = 7'd64;
        end else begin
            nc_clamped_s = data_in[6:0];
        end
        i_next_s = i_q + 7'd1;
    end

    // Next-state and next-output computation for the scan sequencer
    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        nc_d       = nc_q;
        q_d        = q_q;
        best_idx_d = best_idx_q;
        best_q_d   = best_q_q;
        best_sc_d  = best_sc_q;
        address_d  = address_q;
        wr_en_d    = 1'b0;
        data_out_d = data_out_q;
        done_d     = done_q;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    done_d     = 1'b0;
                    i_d        = 7'd0;
                    best_idx_d = NONE_WORD;
                    best_q_d   = NONE_WORD;
                    best_sc_d  = 16'd0;
                    address_d  = NCOUNT_ADDR;
                    state_d    = ST_READY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READY: begin
                if (start) begin
                    address_d = NCOUNT_ADDR;
                    state_d   = ST_RD_NC;
                end else begin
                    state_d = ST_READY;
                end
            end
            ST_RD_NC: begin
                nc_d = nc_clamped_s;
                if (nc_clamped_s == 7'd0) begin
                    state_d = ST_WR_BEST;
                end else begin
                    address_d = QVALUE_BASE;
                    state_d   = ST_RD_Q;
                end
            end
            ST_RD_Q: begin
                q_d       = data_in;
                address_d = table_addr(SIDCOUNT_BASE, i_q);
                state_d   = ST_RD_SC;
            end
            ST_RD_SC: begin
                if (win_s) begin
                    best_idx_d = {9'd0, i_q};
                    best_q_d   = q_q;
                    best_sc_d  = data_in;
                end else begin
                    best_idx_d = best_idx_q;
                end
                i_d = i_next_s;
                if (i_next_s == nc_q) begin
                    state_d = ST_WR_BEST;
                end else begin
                    address_d = table_addr(QVALUE_BASE, i_next_s);
                    state_d   = ST_RD_Q;
                end
            end
            ST_WR_BEST: begin
                address_d  = BEST_ADDR;
                data_out_d = best_idx_q;
                wr_en_d    = 1'b1;
                state_d    = ST_WR_MINQ_GAP;
            end
            // Idle cycle so the write strobe never stays high back to back
            ST_WR_MINQ_GAP: begin
                state_d = ST_WR_MINQ;
            end
            ST_WR_MINQ: begin
                address_d  = MINQ_ADDR;
                data_out_d = best_q_q;
                wr_en_d    = 1'b1;
                state_d    = ST_FIN;
            end
            ST_FIN: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs, synchronous active-high reset
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            i_q        <= 7'd0;
            nc_q       <= 7'd0;
            q_q        <= 16'd0;
            best_idx_q <= NONE_WORD;
            best_q_q   <= NONE_WORD;
            best_sc_q  <= 16'd0;
            address_q  <= NCOUNT_ADDR;
            wr_en_q    <= 1'b0;
            data_out_q <= 16'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            nc_q       <= nc_d;
            q_q        <= q_d;
            best_idx_q <= best_idx_d;
            best_q_q   <= best_q_d;
            best_sc_q  <= best_sc_d;
            address_q  <= address_d;
            wr_en_q    <= wr_en_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
        end
    end

    assign address  = address_q;
    assign wr_en    = wr_en_q;
    assign data_out = data_out_q;
    assign done     = done_q;

endmodule

// File: tb/tb_select_best_neighbor.sv
// Directed self-checking bench for select_best_neighbor against a simple
// word memory model that records the stage's write-backs.
module tb_select_best_neighbor;
    import mem_map_pkg::*;

    logic        clock = 1'b0;
    logic        rst   = 1'b0;
    logic        en    = 1'b0;
    logic        start = 1'b0;
    logic [15:0] data_in;
    logic [10:0] address;
    logic        wr_en;
    logic [15:0] data_out;
    logic        done;

    select_best_neighbor dut (
        .clock    (clock),
        .rst      (rst),
        .en       (en),
        .start    (start),
        .data_in  (data_in),
        .address  (address),
        .wr_en    (wr_en),
        .data_out (data_out),
        .done     (done)
    );

    always #5 clock = ~clock;

    logic [15:0] mem [0:2047];
    assign data_in = mem[address];

    int compared   = 0;
    int mismatched = 0;

    int          wr_total    = 0;
    int          dbl_wr      = 0;
    int          stray_wr    = 0;
    int          tbl_reads   = 0;
    logic        prev_wr     = 1'b0;
    logic [10:0] last_q_addr = 11'd0;
    logic [15:0] best_wr     = 16'd0;
    logic [15:0] minq_wr     = 16'd0;

    // Memory-side observer: captures write-backs and table address activity
    always @(posedge clock) begin
        if (wr_en === 1'b1) begin
            wr_total++;
            if (address == BEST_ADDR) best_wr = data_out;
            else if (address == MINQ_ADDR) minq_wr = data_out;
            else stray_wr++;
        end
        if (prev_wr === 1'b1 && wr_en === 1'b1) dbl_wr++;
        prev_wr = wr_en;
        if (address >= QVALUE_BASE && address < QVALUE_BASE + 11'd400) begin
            last_q_addr = address;
            tbl_reads++;
        end
        if (address >= SIDCOUNT_BASE && address < SIDCOUNT_BASE + 11'd128) tbl_reads++;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_tables;
        for (int k = 0; k < 200; k++) mem[int'(QVALUE_BASE) + 2*k] = 16'd0;
        for (int k = 0; k < 64; k++) mem[int'(SIDCOUNT_BASE) + 2*k] = 16'd0;
    endtask

    task automatic load3(input logic [15:0] q0, q1, q2, s0, s1, s2);
        clear_tables();
        mem[int'(NCOUNT_ADDR)] = 16'd3;
        mem[int'(QVALUE_BASE)]     = q0;
        mem[int'(QVALUE_BASE) + 2] = q1;
        mem[int'(QVALUE_BASE) + 4] = q2;
        mem[int'(SIDCOUNT_BASE)]     = s0;
        mem[int'(SIDCOUNT_BASE) + 2] = s1;
        mem[int'(SIDCOUNT_BASE) + 4] = s2;
    endtask

    task automatic arm;
        en = 1'b1;
        tick();
        en = 1'b0;
    endtask

    // Latency counts edges from the one that samples start until done is seen
    task automatic run_scan(output int lat);
        lat   = -1;
        start = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            tick();
            start = 1'b0;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b expected 0", done); end
        compared++; if (wr_en !== 1'b0) begin mismatched++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
        compared++; if (address !== 11'h68A) begin mismatched++; $display("FAIL reset_address: got %h expected 68a", address); end
        compared++; if (data_out !== 16'h0000) begin mismatched++; $display("FAIL reset_data_out: got %h expected 0000", data_out); end
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        compared++; if (address !== 11'h68A) begin mismatched++; $display("FAIL idle_start_ignored: address %h expected 68a", address); end
    endtask

    task automatic test_basic;
        int lat;
        int w0;
        load3(16'd40, 16'd25, 16'd31, 16'd2, 16'd1, 16'd4);
        w0 = wr_total;
        arm();
        run_scan(lat);
        compared++; if (lat !== 12) begin mismatched++; $display("FAIL basic_latency: got %0d expected 12", lat); end
        compared++; if (best_wr !== 16'd1) begin mismatched++; $display("FAIL basic_best: got %0d expected 1", best_wr); end
        compared++; if (minq_wr !== 16'd25) begin mismatched++; $display("FAIL basic_minq: got %0d expected 25", minq_wr); end
        compared++; if (wr_total - w0 !== 2) begin mismatched++; $display("FAIL basic_wr_pulses: got %0d expected 2", wr_total - w0); end
        tick();
        tick();
        compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL basic_done_held: got %b expected 1", done); end
    endtask

    task automatic test_tiebreak;
        int lat;
        load3(16'd10, 16'd10, 16'd10, 16'd1, 16'd3, 16'd3);
        arm();
        run_scan(lat);
        compared++; if (lat !== 12) begin mismatched++; $display("FAIL tie_latency: got %0d expected 12", lat); end
        compared++; if (best_wr !== 16'd1) begin mismatched++; $display("FAIL tie_best: got %0d expected 1", best_wr); end
        compared++; if (minq_wr !== 16'd10) begin mismatched++; $display("FAIL tie_minq: got %0d expected 10", minq_wr); end
    endtask

    task automatic test_nc_zero;
        int lat;
        int r0;
        int w0;
        clear_tables();
        mem[int'(NCOUNT_ADDR)] = 16'd0;
        r0 = tbl_reads;
        w0 = wr_total;
        arm();
        run_scan(lat);
        compared++; if (lat !== 6) begin mismatched++; $display("FAIL nc0_latency: got %0d expected 6", lat); end
        compared++; if (best_wr !== 16'hFFFF) begin mismatched++; $display("FAIL nc0_best: got %h expected ffff", best_wr); end
        compared++; if (minq_wr !== 16'hFFFF) begin mismatched++; $display("FAIL nc0_minq: got %h expected ffff", minq_wr); end
        compared++; if (tbl_reads - r0 !== 0) begin mismatched++; $display("FAIL nc0_table_reads: got %0d expected 0", tbl_reads - r0); end
        compared++; if (wr_total - w0 !== 2) begin mismatched++; $display("FAIL nc0_wr_pulses: got %0d expected 2", wr_total - w0); end
    endtask

    task automatic test_ffff_values;
        int lat;
        int w0;
        clear_tables();
        mem[int'(NCOUNT_ADDR)] = 16'd2;
        mem[int'(QVALUE_BASE)]     = 16'hFFFF;
        mem[int'(QVALUE_BASE) + 2] = 16'hFFFF;
        mem[int'(SIDCOUNT_BASE) + 2] = 16'd5;
        arm();
        run_scan(lat);
        compared++; if (lat !== 10) begin mismatched++; $display("FAIL ffff_sc_latency: got %0d expected 10", lat); end
        compared++; if (best_wr !== 16'd1) begin mismatched++; $display("FAIL ffff_sc_best: got %h expected 0001", best_wr); end
        compared++; if (minq_wr !== 16'hFFFF) begin mismatched++; $display("FAIL ffff_sc_minq: got %h expected ffff", minq_wr); end
        clear_tables();
        mem[int'(NCOUNT_ADDR)] = 16'd1;
        mem[int'(QVALUE_BASE)] = 16'hFFFF;
        w0 = wr_total;
        arm();
        run_scan(lat);
        compared++; if (best_wr !== 16'hFFFF) begin mismatched++; $display("FAIL ffff_none_best: got %h expected ffff", best_wr); end
        compared++; if (wr_total - w0 !== 2) begin mismatched++; $display("FAIL ffff_none_wr_pulses: got %0d expected 2", wr_total - w0); end
    endtask

    task automatic test_clamp;
        int lat;
        clear_tables();
        mem[int'(NCOUNT_ADDR)] = 16'd200;
        for (int k = 0; k < 200; k++) mem[int'(QVALUE_BASE) + 2*k] = 16'd100;
        mem[int'(QVALUE_BASE) + 126] = 16'd0;
        mem[int'(QVALUE_BASE) + 128] = 16'd0;
        arm();
        run_scan(lat);
        compared++; if (lat !== 134) begin mismatched++; $display("FAIL clamp_latency: got %0d expected 134", lat); end
        compared++; if (best_wr !== 16'd63) begin mismatched++; $display("FAIL clamp_best: got %0d expected 63", best_wr); end
        compared++; if (minq_wr !== 16'd0) begin mismatched++; $display("FAIL clamp_minq: got %0d expected 0", minq_wr); end
        compared++; if (last_q_addr !== 11'h246) begin mismatched++; $display("FAIL clamp_last_q_addr: got %h expected 246", last_q_addr); end
    endtask

    task automatic test_mid_reset;
        int w0;
        load3(16'd40, 16'd25, 16'd31, 16'd2, 16'd1, 16'd4);
        arm();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL midrst_done: got %b expected 0", done); end
        compared++; if (wr_en !== 1'b0) begin mismatched++; $display("FAIL midrst_wr_en: got %b expected 0", wr_en); end
        compared++; if (address !== 11'h68A) begin mismatched++; $display("FAIL midrst_address: got %h expected 68a", address); end
        w0 = wr_total;
        start = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        start = 1'b0;
        compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL midrst_start_no_en_done: got %b expected 0", done); end
        compared++; if (wr_total !== w0) begin mismatched++; $display("FAIL midrst_start_no_en_writes: got %0d expected %0d", wr_total, w0); end
        // Reset landing on the final write cycle must keep done low
        clear_tables();
        mem[int'(NCOUNT_ADDR)] = 16'd0;
        arm();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        compared++; if (wr_en !== 1'b1) begin mismatched++; $display("FAIL wrrst_pre_wr_en: got %b expected 1", wr_en); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        compared++; if (wr_en !== 1'b0) begin mismatched++; $display("FAIL wrrst_wr_en: got %b expected 0", wr_en); end
        compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL wrrst_done: got %b expected 0", done); end
    endtask

    task automatic test_back_to_back;
        int lat;
        int w0;
        load3(16'd40, 16'd25, 16'd31, 16'd2, 16'd1, 16'd4);
        start = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL b2b_idle_start_done: got %b expected 0", done); end
        w0 = wr_total;
        arm();
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            en = (k == 3) ? 1'b1 : 1'b0;
            tick();
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        en = 1'b0;
        compared++; if (lat !== 12) begin mismatched++; $display("FAIL b2b_latency: got %0d expected 12", lat); end
        compared++; if (best_wr !== 16'd1) begin mismatched++; $display("FAIL b2b_best: got %0d expected 1", best_wr); end
        compared++; if (minq_wr !== 16'd25) begin mismatched++; $display("FAIL b2b_minq: got %0d expected 25", minq_wr); end
        for (int k = 0; k < 4; k++) tick();
        start = 1'b0;
        compared++; if (wr_total - w0 !== 2) begin mismatched++; $display("FAIL b2b_wr_pulses: got %0d expected 2", wr_total - w0); end
        compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL b2b_done_held: got %b expected 1", done); end
    endtask

    initial begin
        for (int k = 0; k < 2048; k++) mem[k] = 16'd0;
        test_reset();
        test_basic();
        test_tiebreak();
        test_nc_zero();
        test_ffff_values();
        test_clamp();
        test_mid_reset();
        test_back_to_back();
        compared++; if (dbl_wr !== 0) begin mismatched++; $display("FAIL wr_en_consecutive: got %0d expected 0", dbl_wr); end
        compared++; if (stray_wr !== 0) begin mismatched++; $display("FAIL stray_writes: got %0d expected 0", stray_wr); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
